// File: rtl/complex_mult_mod.sv
// complex_mult_mod: sequential shift-and-add complex multiplier.
// Computes (A1 + jA2) * (B1 + jB2) on two's-complement operands using
// four magnitude accumulators, one multiplier bit per cycle.
// Ports:
//   clk, rst_n         - rising-edge clock, asynchronous active-low reset
//   Op                 - pipeline opcode; Op == MUL_OP in IDLE issues a multiply
//   A1, A2             - real / imaginary multiplicand
//   B1, B2             - real / imaginary multiplier
//   Out1, Out2         - real / imaginary product window, registered
//   Stall              - combinational; high while the unit holds the pipeline
module complex_mult_mod #(
    parameter int unsigned                DATA_SIZE = 8,
    parameter int unsigned                OP_SIZE   = 4,
    parameter logic [OP_SIZE-1:0]         MUL_OP    = OP_SIZE'(4'b0010),
    parameter int unsigned                FRAC_BITS = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OP_SIZE-1:0]    Op,
    input  logic [DATA_SIZE-1:0]  A1,
    input  logic [DATA_SIZE-1:0]  A2,
    input  logic [DATA_SIZE-1:0]  B1,
    input  logic [DATA_SIZE-1:0]  B2,
    output logic [DATA_SIZE-1:0]  Out1,
    output logic [DATA_SIZE-1:0]  Out2,
    output logic                  Stall
);

    localparam int unsigned AW = 2 * DATA_SIZE;      // magnitude accumulator width
    localparam int unsigned PW = 2 * DATA_SIZE + 1;  // signed full-precision width
    localparam int unsigned CW = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DATA_SIZE-1:0]   mag_a1, mag_a2, mag_b1, mag_b2;
    logic                   sgn_a1, sgn_a2, sgn_b1, sgn_b2;
    logic [AW-1:0]          acc11, acc22, acc12, acc21;

    logic [CW-1:0]          k;
    logic [DATA_SIZE-1:0]   sel;
    logic [AW-1:0]          sh_a1, sh_a2;
    logic [AW-1:0]          nxt11, nxt22, nxt12, nxt21;
    logic [PW-1:0]          p11, p22, p12, p21;
    logic [PW-1:0]          re, im;

    // Two's-complement magnitude; the most negative value maps to 2^(DATA_SIZE-1).
    function automatic logic [DATA_SIZE-1:0] mag_of(input logic [DATA_SIZE-1:0] x);
        return x[DATA_SIZE-1] ? DATA_SIZE'(0) - x : x;
    endfunction

    // Signed extension of a magnitude product, negated when the operand signs differ.
    function automatic logic [PW-1:0] signed_of(input logic [AW-1:0] m, input logic neg);
        return neg ? PW'(0) - PW'(m) : PW'(m);
    endfunction

    // Partial products for the current iteration and the final signed sums.
    always_comb begin
        k     = CW'(DATA_SIZE) - cnt;
        sel   = DATA_SIZE'(1) << k;
        sh_a1 = AW'(mag_a1) << k;
        sh_a2 = AW'(mag_a2) << k;
        nxt11 = acc11 + ((|(mag_b1 & sel)) ? sh_a1 : AW'(0));
        nxt22 = acc22 + ((|(mag_b2 & sel)) ? sh_a2 : AW'(0));
        nxt12 = acc12 + ((|(mag_b2 & sel)) ? sh_a1 : AW'(0));
        nxt21 = acc21 + ((|(mag_b1 & sel)) ? sh_a2 : AW'(0));
        p11   = signed_of(nxt11, sgn_a1 ^ sgn_b1);
        p22   = signed_of(nxt22, sgn_a2 ^ sgn_b2);
        p12   = signed_of(nxt12, sgn_a1 ^ sgn_b2);
        p21   = signed_of(nxt21, sgn_a2 ^ sgn_b1);
        re    = p11 - p22;
        im    = p12 + p21;
    end

    // Reset gates Stall so it is low while rst_n is asserted whatever Op is.
    assign Stall = rst_n && (((state == IDLE) && (Op == MUL_OP)) || (state == RUN));

    // Control FSM, operand capture, accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mag_a1 <= '0;
            mag_a2 <= '0;
            mag_b1 <= '0;
            mag_b2 <= '0;
            sgn_a1 <= 1'b0;
            sgn_a2 <= 1'b0;
            sgn_b1 <= 1'b0;
            sgn_b2 <= 1'b0;
            acc11  <= '0;
            acc22  <= '0;
            acc12  <= '0;
            acc21  <= '0;
            Out1   <= '0;
            Out2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Op == MUL_OP) begin
                        mag_a1 <= mag_of(A1);
                        mag_a2 <= mag_of(A2);
                        mag_b1 <= mag_of(B1);
                        mag_b2 <= mag_of(B2);
                        sgn_a1 <= A1[DATA_SIZE-1];
                        sgn_a2 <= A2[DATA_SIZE-1];
                        sgn_b1 <= B1[DATA_SIZE-1];
                        sgn_b2 <= B2[DATA_SIZE-1];
                        acc11  <= '0;
                        acc22  <= '0;
                        acc12  <= '0;
                        acc21  <= '0;
                        cnt    <= CW'(DATA_SIZE);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc11 <= nxt11;
                    acc22 <= nxt22;
                    acc12 <= nxt12;
                    acc21 <= nxt21;
                    cnt   <= cnt - CW'(1);
                    // Last iteration: the sums already include this cycle's partial products.
                    if (cnt == CW'(1)) begin
                        Out1  <= DATA_SIZE'(re >> FRAC_BITS);
                        Out2  <= DATA_SIZE'(im >> FRAC_BITS);
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_mult_mod.sv
// Scoreboard bench for complex_mult_mod: the driver queues hand-computed
// products, the monitor compares on each Stall falling edge (DONE cycle).
module tb_complex_mult_mod;

    localparam int unsigned DS  = 8;
    localparam logic [3:0]  MUL = 4'b0010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    op;
    logic [DS-1:0] a1, a2, b1, b2;
    logic [DS-1:0] out1, out2, f_out1, f_out2;
    logic          stall, f_stall;

    typedef struct packed {
        logic [DS-1:0] r;
        logic [DS-1:0] i;
    } res_t;

    res_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    complex_mult_mod #(.DATA_SIZE(8), .OP_SIZE(4), .MUL_OP(4'b0010), .FRAC_BITS(0)) dut (
        .clk(clk), .rst_n(rst_n), .Op(op),
        .A1(a1), .A2(a2), .B1(b1), .B2(b2),
        .Out1(out1), .Out2(out2), .Stall(stall)
    );

    complex_mult_mod #(.DATA_SIZE(8), .OP_SIZE(4), .MUL_OP(4'b0010), .FRAC_BITS(7)) dut_frac (
        .clk(clk), .rst_n(rst_n), .Op(op),
        .A1(a1), .A2(a2), .B1(b1), .B2(b2),
        .Out1(f_out1), .Out2(f_out2), .Stall(f_stall)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: a Stall falling edge outside reset marks the DONE cycle.
    logic prev_stall = 1'b0;
    int   run_len    = 0;
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall && !stall) begin
                check("stall_length", 16'(run_len), 16'(DS + 1));
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got 0x%0h/0x%0h, expected none", out1, out2);
                end else begin
                    e = exp_q.pop_front();
                    check("out1", 16'(out1), 16'(e.r));
                    check("out2", 16'(out2), 16'(e.i));
                end
            end
            run_len    = stall ? run_len + 1 : 0;
            prev_stall = stall;
        end
    end

    // Issue one multiply; call at posedge+1 with the DUT in IDLE, returns at posedge+1 in IDLE.
    task automatic run_mul(input logic [DS-1:0] xa1, xa2, xb1, xb2,
                           input logic [DS-1:0] e1, e2, input bit scramble);
        res_t e;
        op = MUL; a1 = xa1; a2 = xa2; b1 = xb1; b2 = xb2;
        e.r = e1; e.i = e2;
        exp_q.push_back(e);
        @(posedge clk); #1;
        op = 4'h0;
        for (int c = 0; c < int'(DS); c++) begin
            if (scramble) begin
                a1 = DS'($urandom); a2 = DS'($urandom);
                b1 = DS'($urandom); b2 = DS'($urandom);
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        op = MUL; a1 = 8'd3; a2 = 8'd2; b1 = 8'd1; b2 = 8'd4;
        #2;
        check("reset_stall", 16'(stall), 16'(0));
        check("reset_out1", 16'(out1), 16'(0));
        check("reset_out2", 16'(out2), 16'(0));
        op = 4'h0;
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // (3+2j)(1+4j) = -5 + 14j
        run_mul(8'd3, 8'd2, 8'd1, 8'd4, 8'hFB, 8'h0E, 1'b0);

        // Non-MUL opcode in IDLE: no stall, result held
        op = 4'h5; #1;
        check("idle_stall", 16'(stall), 16'(0));
        @(posedge clk); #1;
        check("idle_hold_out1", 16'(out1), 16'h00FB);
        check("idle_hold_out2", 16'(out2), 16'h000E);
        op = 4'h0;

        // (-128)(-128) = 16384: wraps to 0, FRAC_BITS=7 window gives 0x80
        run_mul(8'h80, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
        check("frac7_out1", 16'(f_out1), 16'h0080);
        check("frac7_out2", 16'(f_out2), 16'h0000);

        // (2-j)(3+j) = 7 - j, operands scrambled after capture
        run_mul(8'd2, 8'hFF, 8'd3, 8'd1, 8'h07, 8'hFF, 1'b1);

        // Reset in RUN cycle 4 aborts; outputs drop immediately
        op = MUL; a1 = 8'd5; a2 = 8'd3; b1 = 8'd7; b2 = 8'd2;
        @(posedge clk); #1;
        op = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("prereset_stall", 16'(stall), 16'(1));
        op = MUL;
        rst_n = 1'b0;
        #1;
        check("abort_stall", 16'(stall), 16'(0));
        check("abort_out1", 16'(out1), 16'(0));
        check("abort_out2", 16'(out2), 16'(0));
        op = 4'h0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // (1+j)(1-j) = 2
        run_mul(8'd1, 8'd1, 8'd1, 8'hFF, 8'h02, 8'h00, 1'b0);

        // Back-to-back: 1*(5+6j) then j*(5+6j) = -6 + 5j
        run_mul(8'd1, 8'd0, 8'd5, 8'd6, 8'h05, 8'h06, 1'b0);
        run_mul(8'd0, 8'd1, 8'd5, 8'd6, 8'hFA, 8'h05, 1'b0);

        op = 4'h9; #1;
        check("final_idle_stall", 16'(stall), 16'(0));
        repeat (2) @(posedge clk);
        #1;
        check("final_hold_out1", 16'(out1), 16'h00FA);
        check("final_hold_out2", 16'(out2), 16'h0005);
        check("queue_empty", 16'(exp_q.size()), 16'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/complex_mult_mod.md
COMPLEX_MULT_MOD -- requirements
Module: complex_mult_mod

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, operand/result component width.
REQ-002 SHALL have parameter OP_SIZE, default 4, opcode width.
REQ-003 SHALL have parameter MUL_OP, default 4'b0010, opcode selecting this unit.
REQ-004 SHALL have parameter FRAC_BITS, default 0, result right-shift selecting the output window (0..DATA_SIZE).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Op  input  OP_SIZE  current pipeline opcode.
REQ-008 SHALL have ports A1, A2  input  DATA_SIZE  real, imaginary parts of multiplicand, two's complement.
REQ-009 SHALL have ports B1, B2  input  DATA_SIZE  real, imaginary parts of multiplier, two's complement.
REQ-010 SHALL have ports Out1, Out2  output  DATA_SIZE  real, imaginary parts of product, registered.
REQ-011 SHALL have port Stall  output  1  high while the unit holds the pipeline.

Function
REQ-012 SHALL compute Out1 = A1*B1 - A2*B2, Out2 = A1*B2 + A2*B1 (signed, full precision 2*DATA_SIZE+1 bits), then output bits [FRAC_BITS+DATA_SIZE-1:FRAC_BITS], wrap-around, no saturation.
REQ-013 SHALL implement FSM IDLE, RUN, DONE.
REQ-014 IDLE: on posedge with Op==MUL_OP, SHALL capture |A1|,|A2|,|B1|,|B2| (DATA_SIZE-bit unsigned; -2^(DATA_SIZE-1) maps to 2^(DATA_SIZE-1)) and the four sign bits, clear four 2*DATA_SIZE-bit accumulators, load iteration counter with DATA_SIZE, go RUN; otherwise stay IDLE.
REQ-015 RUN: each cycle SHALL, for iteration k (0 first), add |A1|<<k to acc11 if |B1| bit k set, |A2|<<k to acc22 if |B2| bit k, |A1|<<k to acc12 if |B2| bit k, |A2|<<k to acc21 if |B1| bit k; decrement counter.
REQ-016 RUN SHALL last exactly DATA_SIZE cycles; on the last RUN edge SHALL apply per-product sign (sA^sB negates), form both sums, register Out1/Out2, go DONE.
REQ-017 DONE SHALL last one cycle, then go IDLE unconditionally regardless of Op.
REQ-018 Stall SHALL be combinational: 1 when (state==IDLE and Op==MUL_OP) or state==RUN; 0 in DONE and when Op!=MUL_OP in IDLE.
REQ-019 Issue-to-result latency: Stall high DATA_SIZE+1 consecutive cycles, Out valid in the DONE cycle (Stall low).
REQ-020 Operand inputs SHALL be ignored after the capture edge; changes during RUN/DONE do not affect the result.
REQ-021 Op leaving MUL_OP during RUN SHALL NOT abort; computation completes, Out updates.
REQ-022 Out1/Out2 SHALL hold last result until the next DONE transition; a new MUL issued in the IDLE cycle after DONE starts a fresh operation.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, accumulators 0, Out1=Out2=0, and Stall=0 regardless of Op.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; after release, next Op==MUL_OP starts a fresh operation from IDLE.

Verification
REQ-025 A=(3,2), B=(1,4), Op=MUL_OP -> Stall high 9 cycles, DONE cycle Out1=0xFB (-5), Out2=0x0E (14).
REQ-026 A=(-128,0), B=(-128,0) -> Out1=0x00 (16384 wraps), Out2=0x00; with FRAC_BITS=7, Out1=0x80.
REQ-027 A=(2,-1), B=(3,1); A/B driven to random values from the cycle after capture -> Out1=0x07, Out2=0xFF.
REQ-028 rst_n pulsed low at RUN cycle 4 -> Stall and Out1/Out2 drop to 0 immediately; subsequent MUL of (1,1)*(1,-1) -> Out1=0x02, Out2=0x00.
REQ-029 Two MULs back-to-back, (1,0)*(5,6) then (0,1)*(5,6) -> first DONE Out=(5,6), IDLE issue cycle with Stall=1, second DONE Out=(0xFA,5); Op≠MUL_OP in IDLE -> Stall=0, Out held.
